// File: rtl/pregfile_mp_pkg.sv
// Shared definitions for the multi-port physical register file:
// default geometry and the init-engine state encoding.
package pregfile_mp_pkg;

    localparam int PREG_LENGTH = 6;    // index width at the default depth
    localparam int PREG_RANGE  = 64;   // default number of physical registers
    localparam int DATA_W_DEF  = 64;   // default register width

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/pregfile_bypass_mux.sv
// Per-read-port value selection: same-cycle write bypass with
// highest-numbered-port priority, then array data, then zero-preg masking.
module pregfile_bypass_mux
    import pregfile_mp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = PREG_LENGTH,
    parameter int NUM_WR    = 2,
    parameter int ZERO_PREG = 1
) (
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic [DATA_W-1:0]        arr_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_val
);

    // Later ports overwrite earlier matches, so the highest port wins.
    always_comb begin
        rd_val = arr_data;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_idx[j*IDX_W +: IDX_W] == rd_idx)) begin
                rd_val = wr_data[j*DATA_W +: DATA_W];
            end
        end
        if ((ZERO_PREG != 0) && (rd_idx == '0)) begin
            rd_val = '0;
        end
    end

endmodule

// File: rtl/pregfile_mp.sv
// Parametrised multi-port physical register file with a sequential clear
// engine, same-cycle write bypass, optional registered read data and a
// write-port index conflict flag.
module pregfile_mp
    import pregfile_mp_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_PREG   = PREG_RANGE,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int RD_LATENCY = 0,
    parameter int ZERO_PREG  = 1,
    localparam int IDX_W     = $clog2(NUM_PREG)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     init_done,
    output logic                     wr_conflict
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PREG - 1);

    if (RD_LATENCY > 1 || RD_LATENCY < 0) begin : g_bad_latency
        $error("pregfile_mp: RD_LATENCY must be 0 or 1");
    end
    if (NUM_PREG < 2 || ((NUM_PREG & (NUM_PREG - 1)) != 0)) begin : g_bad_depth
        $error("pregfile_mp: NUM_PREG must be a power of 2 and at least 2");
    end

    init_state_e       state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready;
    logic [NUM_WR-1:0] wr_en_eff;
    logic              conflict_d;
    logic              wr_conflict_q;

    // No reset on the array so it can map onto RAM; the clear engine zeroes it.
    logic [DATA_W-1:0] mem [NUM_PREG];

    assign ready       = (state_q == READY);
    assign wr_en_eff   = wr_en & {NUM_WR{ready}};
    assign init_done   = ready;
    assign wr_conflict = wr_conflict_q;

    // Init engine state and clear pointer; any reset restarts the sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Init engine next state: sweep every entry once, then park in READY.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Storage update: clear one entry per cycle, then accept port writes
    // with the highest-numbered port landing last.
    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_eff[j] &&
                    !((ZERO_PREG != 0) && (wr_idx[j*IDX_W +: IDX_W] == '0))) begin
                    mem[wr_idx[j*IDX_W +: IDX_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Pairwise compare of enabled write ports; hits on a hardwired-zero preg are harmless.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en_eff[i] && wr_en_eff[j] &&
                    (wr_idx[i*IDX_W +: IDX_W] == wr_idx[j*IDX_W +: IDX_W]) &&
                    !((ZERO_PREG != 0) && (wr_idx[i*IDX_W +: IDX_W] == '0))) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // One-cycle conflict pulse reported the cycle after the colliding writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [DATA_W-1:0] arr_k;
        logic [DATA_W-1:0] v_k;

        assign arr_k = mem[rd_idx[k*IDX_W +: IDX_W]];

        pregfile_bypass_mux #(
            .DATA_W    (DATA_W),
            .IDX_W     (IDX_W),
            .NUM_WR    (NUM_WR),
            .ZERO_PREG (ZERO_PREG)
        ) u_bypass (
            .rd_idx   (rd_idx[k*IDX_W +: IDX_W]),
            .arr_data (arr_k),
            .wr_en    (wr_en_eff),
            .wr_idx   (wr_idx),
            .wr_data  (wr_data),
            .rd_val   (v_k)
        );

        if (RD_LATENCY == 0) begin : g_comb
            assign rd_data[k*DATA_W +: DATA_W] = (ready && rd_en[k]) ? v_k : '0;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_q_p1;

            // ---- stage p1: registered read data, held while the port is idle ----
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_q_p1 <= '0;
                end else if (!ready) begin
                    rd_q_p1 <= '0;
                end else if (rd_en[k]) begin
                    rd_q_p1 <= v_k;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = rd_q_p1;
        end
    end

endmodule

// File: doc/pregfile_mp.md
Name: pregfile_mp

Overview:
- Parametrised multi-port physical integer register file for the backend. Successor to the fixed 2R/2W 64-entry file.
- Configurable width, depth, read and write port counts, and read latency (0 = combinational, 1 = registered).
- Clears entries with a sequential init engine instead of a reset-time array clear, so the storage maps to RAM.
- Sits between rename/issue (reads) and writeback (writes). Reports same-cycle write-port index conflicts.

Parameters:
- DATA_W, 64, bits per register
- NUM_PREG, 64, number of physical registers (power of 2, at least 2)
- IDX_W, $clog2(NUM_PREG), index width (derived, not overridden)
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports
- RD_LATENCY, 0, read latency in cycles; legal values 0 or 1
- ZERO_PREG, 1, when 1, preg 0 ignores writes and always reads 0

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- rd_en  in  NUM_RD  per-port read enable
- rd_idx  in  NUM_RD*IDX_W  read indices; port k in bits [k*IDX_W +: IDX_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- wr_en  in  NUM_WR  per-port write enable
- wr_idx  in  NUM_WR*IDX_W  write indices
- wr_data  in  NUM_WR*DATA_W  write data
- init_done  out  1  high once every entry has been cleared
- wr_conflict  out  1  one-cycle pulse: previous cycle had two or more enabled write ports targeting the same writable index

Behaviour:
- Reset (async assert): init FSM goes to CLEAR with clr_cnt=0. init_done=0, wr_conflict=0, registered rd_data=0. The storage array has no reset.
- FSM CLEAR: each cycle writes 0 to entry clr_cnt, then increments clr_cnt. After entry NUM_PREG-1 is written, next state is READY; init_done rises on that edge. CLEAR therefore lasts exactly NUM_PREG cycles after reset deassertion.
- FSM READY: terminal state. Only reset leaves it. A reset in mid-CLEAR restarts at clr_cnt=0.
- During CLEAR:
  - all wr_en are ignored and wr_conflict stays 0;
  - all rd_data read 0 (combinational), or are loaded with 0 (RD_LATENCY=1).
- Writes (READY only):
  - on posedge, entry wr_idx[j] <= wr_data[j] for each enabled j;
  - writes to index 0 are dropped when ZERO_PREG=1;
  - if several ports hit the same index, the highest-numbered port wins.
- Read value v(k), evaluated for each port k:
  - 0 if ZERO_PREG=1 and rd_idx[k]==0;
  - otherwise wr_data of the highest-numbered enabled write port with wr_idx==rd_idx[k] (same-cycle bypass);
  - otherwise the array entry.
- RD_LATENCY=0:
  - rd_data[k] = v(k) when rd_en[k]=1, else 0;
  - purely combinational, no latches.
- RD_LATENCY=1:
  - on posedge with rd_en[k]=1, rd_data[k] <= v(k). Data is valid the cycle after the request and includes bypass from writes in the request cycle;
  - with rd_en[k]=0, rd_data[k] holds its value.
- Write conflict:
  - set wr_conflict_q <= 1 if any pair i<j has wr_en[i], wr_en[j] both set and wr_idx[i]==wr_idx[j], excluding index 0 when ZERO_PREG=1;
  - otherwise wr_conflict_q <= 0, so the flag pulses for one cycle.
- Read and write of the same index in the same cycle never returns stale data in either latency mode.
- Out-of-range parameters (RD_LATENCY>1, NUM_PREG not a power of 2) trigger an elaboration-time $error.

Decomposition:
- Shared package/defines: PREG_LENGTH/PREG_RANGE (IDX_W at default), DATA_W default, and the init FSM state enum (CLEAR, READY).
- Sub-module pregfile_bypass_mux:
  - one instance per read port;
  - inputs: rd_idx, array data, and all write ports;
  - output: v(k), with highest-port-wins priority and zero-preg masking.
- Top level holds the storage, init FSM, conflict detector, and the optional output register.

Test Plan:
- Init: release reset_n at cycle 0 (defaults) -> init_done=0 for 64 cycles, 1 from cycle 64; wr_en=1 (idx 5, 0xAA) at cycle 10 is ignored; preg 5 reads 0 after init.
- Write/read plus bypass, RD_LATENCY=0: write preg 7=0x1234 while reading idx 7 in the same cycle -> rd_data[0]=0x1234 combinationally and on every following read.
- Zero preg: wr idx 0 data 0xFFFF -> reads of idx 0 return 0; wr_conflict stays 0 even when both ports write idx 0.
- Conflict: wr0 (idx 9, 0x1) and wr1 (idx 9, 0x2) in the same cycle -> wr_conflict=1 for exactly one cycle; preg 9 reads 0x2.
- RD_LATENCY=1: rd_en=1 with idx 3 (value 0x55) at cycle t -> rd_data=0x55 at t+1; rd_en=0 with idx changed -> output still 0x55; a write of 3=0x66 in the request cycle -> 0x66 at t+1.
- Reset mid-CLEAR: assert reset_n=0 at CLEAR cycle 20 and release -> 64 more cycles before init_done; all 4 ports read 0 during CLEAR.
